// File: rtl/pace_poly_eval.sv
// Purpose : piecewise polynomial evaluator; picks a segment by bound compare, then runs Horner one MAC per cycle.
// Latency : PaceDegree+1 edges from acceptance to out_valid_o for polynomial results, 1 edge for epsilon results.
// Backpr. : one operand in flight; in_ready_o low from SEG through DONE, result held in DONE until out_ready_i.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   pace_param_i           flat parameter vector, word w at [w*32 +: 32]:
//                          coefficients (segment-major, c_0 first), P-1 ascending bounds, eps_thr, eps_val
//   in_valid_i/in_ready_o  operand handshake, in_data_i = x (signed Q(32-FracBits).FracBits)
//   out_valid_o/out_ready_i result handshake, out_data_o = y, out_seg_o = segment, out_eps_o = bypass flag
//   busy_o                 high whenever the FSM is not idle
module pace_poly_eval #(
    parameter int PaceDegree    = 2,
    parameter int PaceParts     = 16,
    parameter int PaceEps       = 1,
    parameter int PaceDataWidth = 32,
    parameter int FracBits      = 16,
    localparam int PaceParamWidth =
        ((PaceDegree + 1) * PaceParts + (PaceParts - 1) + 2 * PaceEps) * PaceDataWidth,
    localparam int SegW = $clog2(PaceParts)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [PaceParamWidth-1:0] pace_param_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [PaceDataWidth-1:0]  in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [PaceDataWidth-1:0]  out_data_o,
    output logic [SegW-1:0]           out_seg_o,
    output logic                      out_eps_o,
    output logic                      busy_o
);

    localparam int W        = PaceDataWidth;
    localparam int NumCoef  = (PaceDegree + 1) * PaceParts;
    localparam int BndBase  = NumCoef;
    localparam int EpsBase  = NumCoef + PaceParts - 1;
    localparam int NumWords = EpsBase + 2 * PaceEps;
    localparam int IdxW     = $clog2(NumWords);
    localparam int KW       = $clog2(PaceDegree + 1);

    if (PaceDataWidth != 32) begin : g_width_check
        $error("pace_poly_eval supports only PaceDataWidth = 32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEG  = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]    x_q;
    logic [W-1:0]    acc_q;
    logic [KW-1:0]   k_q;
    logic [SegW-1:0] seg_q;

    // Word view of the live parameter vector.
    logic [W-1:0] words [NumWords];
    for (genvar w = 0; w < NumWords; w++) begin : g_words
        assign words[w] = pace_param_i[w*W +: W];
    end

    // Segment select: smallest i with x < b_i; the descending loop lets the
    // lowest matching index win. Falls through to the last segment.
    logic [SegW-1:0] seg_sel;
    always_comb begin
        seg_sel = SegW'(PaceParts - 1);
        for (int i = PaceParts - 2; i >= 0; i--) begin
            if ($signed(x_q) < $signed(words[BndBase + i])) begin
                seg_sel = SegW'(i);
            end
        end
    end

    // Epsilon bypass. The most negative value has no positive magnitude, so
    // it is excluded explicitly rather than letting its wrapped abs compare.
    logic         eps_hit;
    logic [W-1:0] eps_val;
    if (PaceEps != 0) begin : g_eps
        logic [W-1:0] abs_x;
        assign abs_x   = x_q[W-1] ? -x_q : x_q;
        assign eps_hit = (x_q != {1'b1, {(W-1){1'b0}}}) &&
                         ($signed(abs_x) < $signed(words[EpsBase]));
        assign eps_val = words[EpsBase + 1];
    end else begin : g_no_eps
        assign eps_hit = 1'b0;
        assign eps_val = '0;
    end

    // Coefficient addressing: top coefficient of the newly selected segment
    // in SEG, and c_k of the registered segment during MAC.
    logic [IdxW-1:0] top_idx, mac_idx;
    assign top_idx = IdxW'(int'(seg_sel) * (PaceDegree + 1) + PaceDegree);
    assign mac_idx = IdxW'(int'(seg_q) * (PaceDegree + 1) + int'(k_q));

    // One Horner step: full-width signed product, arithmetic shift back to
    // the Q format (floor), truncate, then a wrapping add of c_k.
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          mac_prod;
    logic [W-1:0]          mac_next;
    assign prod     = $signed({{W{acc_q[W-1]}}, acc_q}) * $signed({{W{x_q[W-1]}}, x_q});
    assign mac_prod = W'(prod >>> FracBits);
    assign mac_next = mac_prod + words[mac_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) begin
                    state_d = SEG;
                end
            end
            SEG: begin
                state_d = eps_hit ? DONE : MAC;
            end
            MAC: begin
                if (k_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath. Result registers load only when entering DONE, so they stay
    // stable through DONE and keep the last result while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q        <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            seg_q      <= '0;
            out_data_o <= '0;
            out_seg_o  <= '0;
            out_eps_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        x_q <= in_data_i;
                    end
                end
                SEG: begin
                    if (eps_hit) begin
                        out_data_o <= eps_val;
                        out_seg_o  <= '0;
                        out_eps_o  <= 1'b1;
                    end else begin
                        seg_q <= seg_sel;
                        acc_q <= words[top_idx];
                        k_q   <= KW'(PaceDegree - 1);
                    end
                end
                MAC: begin
                    acc_q <= mac_next;
                    k_q   <= k_q - KW'(1);
                    if (k_q == '0) begin
                        out_data_o <= mac_next;
                        out_seg_o  <= seg_q;
                        out_eps_o  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pace_poly_eval.sv
module tb_pace_poly_eval;

    localparam int D   = 2;
    localparam int P   = 4;
    localparam int F   = 16;
    localparam int PW  = ((D + 1) * P + (P - 1) + 2) * 32;
    localparam int PW0 = ((D + 1) * P + (P - 1)) * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] pace_param;
    logic          in_valid, in_ready;
    logic [31:0]   in_data;
    logic          out_valid, out_ready;
    logic [31:0]   out_data;
    logic [1:0]    out_seg;
    logic          out_eps, busy;

    logic          in_valid0, in_ready0;
    logic          out_valid0, out_ready0;
    logic [31:0]   out_data0;
    logic [1:0]    out_seg0;
    logic          out_eps0, busy0;

    int checks = 0;
    int errors = 0;

    // Reference parameter set, held as plain arrays.
    int coef [P][D+1];
    int bnd  [P-1];
    int eps_thr;
    int eps_val;

    always #5 clk = ~clk;

    pace_poly_eval #(
        .PaceDegree(D), .PaceParts(P), .PaceEps(1), .PaceDataWidth(32), .FracBits(F)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pace_param_i(pace_param),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_seg_o(out_seg), .out_eps_o(out_eps), .busy_o(busy)
    );

    pace_poly_eval #(
        .PaceDegree(D), .PaceParts(P), .PaceEps(0), .PaceDataWidth(32), .FracBits(F)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .pace_param_i(pace_param[PW0-1:0]),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
        .out_seg_o(out_seg0), .out_eps_o(out_eps0), .busy_o(busy0)
    );

    task automatic build_param();
        pace_param = '0;
        for (int p = 0; p < P; p++)
            for (int k = 0; k <= D; k++)
                pace_param[(p*(D+1)+k)*32 +: 32] = coef[p][k];
        for (int i = 0; i < P-1; i++)
            pace_param[((D+1)*P+i)*32 +: 32] = bnd[i];
        pace_param[((D+1)*P+P-1)*32 +: 32] = eps_thr;
        pace_param[((D+1)*P+P)*32 +: 32]   = eps_val;
    endtask

    task automatic setup_plan();
        coef[0] = '{32'h00030000, 32'hFFFF0000, 32'h00004000};
        coef[1] = '{32'h00001000, 32'h00018000, 32'hFFFFC000};
        coef[2] = '{32'h00010000, 32'h00020000, 32'h00008000};
        coef[3] = '{32'hFFFE8000, 32'h00010000, 32'h00002000};
        bnd     = '{32'hFFFF0000, 32'h00000000, 32'h00010000};
        eps_thr = 32'h00000100;
        eps_val = 32'h7FFFFFFF;
        build_param();
    endtask

    // Behavioural model: magnitude test, linear segment search, Horner in
    // 64-bit integer arithmetic with 32-bit wrapping.
    function automatic void model(input logic [31:0] x, input bit use_eps,
                                  output logic [31:0] y, output logic [1:0] seg,
                                  output logic eps);
        longint xs, mag, pr;
        int     acc, s;
        xs  = longint'($signed(x));
        mag = (xs < 0) ? -xs : xs;
        if (use_eps && mag < longint'(eps_thr)) begin
            y = eps_val; seg = 2'd0; eps = 1'b1;
            return;
        end
        s = P - 1;
        for (int i = 0; i < P-1; i++) begin
            if (xs < longint'(bnd[i])) begin
                s = i;
                break;
            end
        end
        acc = coef[s][D];
        for (int k = D-1; k >= 0; k--) begin
            pr  = longint'(acc) * xs;
            acc = int'(pr >>> F) + coef[s][k];
        end
        y = acc; seg = 2'(s); eps = 1'b0;
    endfunction

    // Present x, wait for acceptance, then count edges until out_valid.
    task automatic do_op(input logic [31:0] x, output logic [31:0] y,
                         output logic [1:0] seg, output logic eps, output int lat);
        int n;
        @(negedge clk);
        in_data = x; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0; y = '0; seg = '0; eps = 1'b0; lat = -1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        y = out_data; seg = out_seg; eps = out_eps;
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_noneps();
        logic [31:0] m;
        m = $urandom_range(32'h00010000, 32'h7FFE0000);
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        setup_plan();
        #12;
        checks++;
        if ({in_ready, out_valid, busy, out_eps} !== 4'b1000 || out_data !== 32'h0 || out_seg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state rdy/vld/busy/eps=%b data=%h seg=%0d required 1000 0 0",
                     {in_ready, out_valid, busy, out_eps}, out_data, out_seg);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_basic();
        logic [31:0] y; logic [1:0] s; logic e; int lat;
        do_op(32'h00008000, y, s, e, lat);
        checks++;
        if (y !== 32'h00022000 || s !== 2'd2 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_result data=%h seg=%0d eps=%b required 00022000 2 0", y, s, e);
        end
        checks++;
        if (lat !== D+1) begin
            errors++;
            $display("FAIL basic_latency got %0d required %0d", lat, D+1);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_flags in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h00022000) begin
            errors++;
            $display("FAIL idle_hold rdy=%b vld=%b busy=%b data=%h required 1 0 0 00022000",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] xs [6];
        logic [1:0]  segs [6];
        logic [31:0] y, ey; logic [1:0] s, es; logic e, ee; int lat;
        xs   = '{32'h00000000, 32'h00010000, 32'h80000000, 32'hFFFFFFF0, 32'h00000100, 32'hFFFF0000};
        segs = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd2, 2'd1};
        for (int i = 0; i < 6; i++) begin
            do_op(xs[i], y, s, e, lat);
            model(xs[i], 1'b1, ey, es, ee);
            checks++;
            if (y !== ey || s !== es || e !== ee || s !== segs[i]) begin
                errors++;
                $display("FAIL boundary_x%h data=%h seg=%0d eps=%b required %h %0d %b",
                         xs[i], y, s, e, ey, segs[i], ee);
            end
            checks++;
            if (lat !== (ee ? 1 : D+1)) begin
                errors++;
                $display("FAIL boundary_lat_x%h got %0d required %0d", xs[i], lat, ee ? 1 : D+1);
            end
            finish_op();
        end
    endtask

    task automatic test_no_eps();
        logic [31:0] ey; logic [1:0] es; logic ee; int n, lat;
        model(32'h0, 1'b0, ey, es, ee);
        @(negedge clk);
        in_data = 32'h0; in_valid0 = 1'b1;
        n = 0;
        while (!in_ready0 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (out_data0 !== ey || out_seg0 !== 2'd2 || out_eps0 !== 1'b0 || lat !== D+1) begin
            errors++;
            $display("FAIL no_eps_zero data=%h seg=%0d eps=%b lat=%0d required %h 2 0 %0d",
                     out_data0, out_seg0, out_eps0, lat, ey, D+1);
        end
        @(negedge clk); out_ready0 = 1'b1;
        @(posedge clk); #1; out_ready0 = 1'b0;
        checks++;
        if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL no_eps_idle rdy=%b busy=%b required 1 0", in_ready0, busy0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] y, ey; logic [1:0] s, es; logic e, ee; int lat;
        do_op(32'hFFFF8000, y, s, e, lat);
        model(32'hFFFF8000, 1'b1, ey, es, ee);
        checks++;
        if (y !== ey || s !== es) begin
            errors++;
            $display("FAIL bp_result data=%h seg=%0d required %h %0d", y, s, ey, es);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== ey || out_seg !== es || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_c%0d vld=%b data=%h seg=%0d rdy=%b required 1 %h %0d 0",
                         c, out_valid, out_data, out_seg, in_ready, ey, es);
            end
        end
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q [$];
        int          acc_cyc [$];
        logic [31:0] x, ey; logic [1:0] es; logic ee;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = rand_noneps();
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious vld=%b required 0", out_valid);
                end else begin
                    x = q.pop_front();
                    model(x, 1'b1, ey, es, ee);
                    if (out_data !== ey || out_seg !== es || out_eps !== ee) begin
                        errors++;
                        $display("FAIL b2b_result x=%h data=%h seg=%0d required %h %0d", x, out_data, out_seg, ey, es);
                    end
                end
            end
            if (in_ready && in_valid) begin
                q.push_back(in_data);
                acc_cyc.push_back(cyc);
            end
            @(posedge clk); #1;
            if (cyc >= 30) in_valid = 1'b0;
            if (!in_ready) in_data = rand_noneps();
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (q.size() != 0 || acc_cyc.size() < 6) begin
            errors++;
            $display("FAIL b2b_count pending=%0d accepted=%0d required 0 >=6", q.size(), acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != D+3) begin
                errors++;
                $display("FAIL b2b_interval_%0d got %0d required %0d", i, acc_cyc[i] - acc_cyc[i-1], D+3);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] y, ey; logic [1:0] s, es; logic e, ee; int lat;
        coef[3] = '{32'h0, 32'h0, 32'h7FFF0000};
        build_param();
        do_op(32'h00020000, y, s, e, lat);
        model(32'h00020000, 1'b1, ey, es, ee);
        checks++;
        if (y !== ey || y !== 32'hFFFC0000 || s !== 2'd3 || e !== 1'b0) begin
            errors++;
            $display("FAIL wrap_result data=%h seg=%0d required %h 3", y, s, ey);
        end
        finish_op();
        setup_plan();
    endtask

    task automatic test_random();
        logic [31:0] x, y, ey; logic [1:0] s, es; logic e, ee; int lat;
        for (int p = 0; p < P; p++)
            for (int k = 0; k <= D; k++)
                coef[p][k] = $urandom;
        eps_val = $urandom;
        build_param();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: x = $urandom;
                1: x = bnd[$urandom_range(0, P-2)] + $urandom_range(0, 4) - 2;
                2: x = ($urandom_range(0, 1) == 1) ? -$urandom_range(0, 600) : $urandom_range(0, 600);
                default: x = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
            endcase
            do_op(x, y, s, e, lat);
            model(x, 1'b1, ey, es, ee);
            checks++;
            if (y !== ey || s !== es || e !== ee || lat !== (ee ? 1 : D+1)) begin
                errors++;
                $display("FAIL random_x%h data=%h seg=%0d eps=%b lat=%0d required %h %0d %b %0d",
                         x, y, s, e, lat, ey, es, ee, ee ? 1 : D+1);
            end
            finish_op();
        end
        setup_plan();
    endtask

    task automatic test_reset_mid();
        logic [31:0] y; logic [1:0] s; logic e; int lat;
        @(negedge clk);
        in_data = 32'h00008000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy busy=%b rdy=%b required 1 0", busy, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset vld=%b rdy=%b busy=%b data=%h required 0 1 0 0",
                     out_valid, in_ready, busy, out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        do_op(32'h00008000, y, s, e, lat);
        checks++;
        if (y !== 32'h00022000 || s !== 2'd2 || e !== 1'b0 || lat !== D+1) begin
            errors++;
            $display("FAIL post_reset data=%h seg=%0d eps=%b lat=%0d required 00022000 2 0 %0d", y, s, e, lat, D+1);
        end
        finish_op();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_no_eps();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
